// File: rtl/binary_target_locator.sv
// rtl/binary_target_locator.sv - per-frame foreground count, bounding box and centre from a binary pixel stream
// Optional LOCATOR_ROI_EN: only foreground pixels inside the ROI_* window are counted.

module binary_target_locator #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int MIN_PIXELS = 16,
  parameter int ROI_X0     = 0,
  parameter int ROI_X1     = IMG_W - 1,
  parameter int ROI_Y0     = 0,
  parameter int ROI_Y1     = IMG_H - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            din_sop,
  input  logic            din_eop,
  input  logic            din_vld,
  output logic            res_vld,
  output logic            obj_found,
  output logic [XW-1:0]   x_min,
  output logic [XW-1:0]   x_max,
  output logic [YW-1:0]   y_min,
  output logic [YW-1:0]   y_max,
  output logic [XW-1:0]   x_cen,
  output logic [YW-1:0]   y_cen,
  output logic [XW+YW-1:0] pix_cnt
);

  localparam int CW = XW + YW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [XW-1:0] acc_x_min_q, acc_x_min_d;
  logic [XW-1:0] acc_x_max_q, acc_x_max_d;
  logic [YW-1:0] acc_y_min_q, acc_y_min_d;
  logic [YW-1:0] acc_y_max_q, acc_y_max_d;

  logic          res_vld_q, res_vld_d;
  logic          obj_found_q, obj_found_d;
  logic [XW-1:0] x_min_q, x_min_d;
  logic [XW-1:0] x_max_q, x_max_d;
  logic [YW-1:0] y_min_q, y_min_d;
  logic [YW-1:0] y_max_q, y_max_d;
  logic [XW-1:0] x_cen_q, x_cen_d;
  logic [YW-1:0] y_cen_q, y_cen_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;

  logic          take;
  logic          in_roi;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;
  logic [CW-1:0] base_cnt;
  logic [XW-1:0] base_x_min;
  logic [XW-1:0] base_x_max;
  logic [YW-1:0] base_y_min;
  logic [YW-1:0] base_y_max;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;

  // A sop pixel is always accepted (even during DONE) and restarts the frame at (0,0).
  assign take  = din_vld && (din_sop || (state_q == S_ACC));
  assign x_cur = din_sop ? '0 : x_q;
  assign y_cur = din_sop ? '0 : y_q;

  assign base_cnt   = din_sop ? '0 : acc_cnt_q;
  assign base_x_min = din_sop ? '1 : acc_x_min_q;
  assign base_x_max = din_sop ? '0 : acc_x_max_q;
  assign base_y_min = din_sop ? '1 : acc_y_min_q;
  assign base_y_max = din_sop ? '0 : acc_y_max_q;

  assign x_sum = {1'b0, acc_x_min_q} + {1'b0, acc_x_max_q};
  assign y_sum = {1'b0, acc_y_min_q} + {1'b0, acc_y_max_q};

`ifdef LOCATOR_ROI_EN
  assign in_roi = (int'(x_cur) >= ROI_X0) && (int'(x_cur) <= ROI_X1) &&
                  (int'(y_cur) >= ROI_Y0) && (int'(y_cur) <= ROI_Y1);
`else
  logic unused_roi_cfg;
  assign in_roi         = 1'b1;
  assign unused_roi_cfg = ^{ROI_X0, ROI_X1, ROI_Y0, ROI_Y1};
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_cnt_d   = acc_cnt_q;
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;

    if (take) begin
      x_d = (x_cur == X_LAST) ? '0 : x_cur + XW'(1);
      y_d = ((x_cur == X_LAST) && (y_cur != Y_LAST)) ? y_cur + YW'(1) : y_cur;

      acc_cnt_d   = base_cnt;
      acc_x_min_d = base_x_min;
      acc_x_max_d = base_x_max;
      acc_y_min_d = base_y_min;
      acc_y_max_d = base_y_max;

      if (din && in_roi) begin
        acc_cnt_d   = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + CW'(1);
        acc_x_min_d = (x_cur < base_x_min) ? x_cur : base_x_min;
        acc_x_max_d = (x_cur > base_x_max) ? x_cur : base_x_max;
        acc_y_min_d = (y_cur < base_y_min) ? y_cur : base_y_min;
        acc_y_max_d = (y_cur > base_y_max) ? y_cur : base_y_max;
      end

      state_d = din_eop ? S_DONE : S_ACC;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  // Result registers sample the accumulators as they stood at eop; a same-cycle sop only affects *_d.
  always_comb begin
    res_vld_d   = 1'b0;
    obj_found_d = obj_found_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    x_cen_d     = x_cen_q;
    y_cen_d     = y_cen_q;
    pix_cnt_d   = pix_cnt_q;

    if (state_q == S_DONE) begin
      res_vld_d = 1'b1;
      pix_cnt_d = acc_cnt_q;
      if (acc_cnt_q >= MIN_CNT) begin
        obj_found_d = 1'b1;
        x_min_d     = acc_x_min_q;
        x_max_d     = acc_x_max_q;
        y_min_d     = acc_y_min_q;
        y_max_d     = acc_y_max_q;
        x_cen_d     = x_sum[XW:1];
        y_cen_d     = y_sum[YW:1];
      end else begin
        obj_found_d = 1'b0;
        x_min_d     = '0;
        x_max_d     = '0;
        y_min_d     = '0;
        y_max_d     = '0;
        x_cen_d     = '0;
        y_cen_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      acc_cnt_q   <= '0;
      acc_x_min_q <= '0;
      acc_x_max_q <= '0;
      acc_y_min_q <= '0;
      acc_y_max_q <= '0;
      res_vld_q   <= 1'b0;
      obj_found_q <= 1'b0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      x_cen_q     <= '0;
      y_cen_q     <= '0;
      pix_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      res_vld_q   <= res_vld_d;
      obj_found_q <= obj_found_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      x_cen_q     <= x_cen_d;
      y_cen_q     <= y_cen_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign res_vld   = res_vld_q;
  assign obj_found = obj_found_q;
  assign x_min     = x_min_q;
  assign x_max     = x_max_q;
  assign y_min     = y_min_q;
  assign y_max     = y_max_q;
  assign x_cen     = x_cen_q;
  assign y_cen     = y_cen_q;
  assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_binary_target_locator.sv
// tb/tb_binary_target_locator.sv - randomized self-checking bench for binary_target_locator
// Define LOCATOR_ROI_EN for both files to exercise the ROI build.

module tb_binary_target_locator;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int MINP = 4;
  localparam int RX0  = 3;
  localparam int RX1  = 7;
  localparam int RY0  = 0;
  localparam int RY1  = 5;
  localparam int CMAX = (1 << (XW + YW)) - 1;

  logic clk = 1'b0;
  logic rst;
  logic din, din_sop, din_eop, din_vld;
  logic res_vld, obj_found;
  logic [XW-1:0] x_min, x_max, x_cen;
  logic [YW-1:0] y_min, y_max, y_cen;
  logic [XW+YW-1:0] pix_cnt;

  int chk_cnt = 0;
  int err_cnt = 0;
  int res_cnt = 0;
  int e_found, e_xmin, e_xmax, e_ymin, e_ymax, e_xcen, e_ycen, e_cnt;
  bit [127:0] img_a, img_b;

  binary_target_locator #(
    .IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .MIN_PIXELS(MINP),
    .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
    .res_vld(res_vld), .obj_found(obj_found), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .x_cen(x_cen), .y_cen(y_cen), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_vld === 1'b1) res_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit roi_hit(input int x, input int y);
`ifdef LOCATOR_ROI_EN
    return (x >= RX0) && (x <= RX1) && (y >= RY0) && (y <= RY1);
`else
    return 1'b1;
`endif
  endfunction

  // Pixel i of a frame sits at column i mod W, row i div W clipped to the last row.
  task automatic model(input bit [127:0] im, input int n);
    int cnt, x0, x1, y0, y1, x, y;
    cnt = 0; x0 = W; x1 = -1; y0 = H; y1 = -1;
    for (int i = 0; i < n; i++) begin
      x = i % W;
      y = (i / W > H - 1) ? H - 1 : i / W;
      if (im[i] && roi_hit(x, y)) begin
        cnt++;
        if (x < x0) x0 = x;
        if (x > x1) x1 = x;
        if (y < y0) y0 = y;
        if (y > y1) y1 = y;
      end
    end
    e_cnt = (cnt > CMAX) ? CMAX : cnt;
    if (cnt >= MINP) begin
      e_found = 1; e_xmin = x0; e_xmax = x1; e_ymin = y0; e_ymax = y1;
      e_xcen = (x0 + x1) / 2; e_ycen = (y0 + y1) / 2;
    end else begin
      e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_xcen = 0; e_ycen = 0;
    end
  endtask

  task automatic drive_pixel(input bit d, input bit s, input bit e, input int gap);
    while (int'($urandom_range(99)) < gap) begin
      din_vld = 1'b0;
      din     = 1'($urandom_range(1));
      din_sop = 1'($urandom_range(1));
      din_eop = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    din_vld = 1'b1; din = d; din_sop = s; din_eop = e;
    @(posedge clk); #1;
    din_vld = 1'b0; din = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic send_frame(input bit [127:0] im, input int n, input int gap, input bit with_eop);
    for (int i = 0; i < n; i++)
      drive_pixel(im[i], i == 0, with_eop && (i == n - 1), gap);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".res_vld"},   32'(res_vld),   1);
    check({tag, ".obj_found"}, 32'(obj_found), e_found);
    check({tag, ".x_min"},     32'(x_min),     e_xmin);
    check({tag, ".x_max"},     32'(x_max),     e_xmax);
    check({tag, ".y_min"},     32'(y_min),     e_ymin);
    check({tag, ".y_max"},     32'(y_max),     e_ymax);
    check({tag, ".x_cen"},     32'(x_cen),     e_xcen);
    check({tag, ".y_cen"},     32'(y_cen),     e_ycen);
    check({tag, ".pix_cnt"},   32'(pix_cnt),   e_cnt);
  endtask

  // Called one cycle after the eop pixel was taken: the strobe is due on the next edge.
  task automatic check_result(input string tag);
    check({tag, ".early"}, 32'(res_vld), 0);
    @(posedge clk); #1;
    check_outputs(tag);
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, 32'(res_vld), 0);
    check({tag, ".hold_x_min"}, 32'(x_min), e_xmin);
    check({tag, ".hold_pix_cnt"}, 32'(pix_cnt), e_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".res_vld"},   32'(res_vld),   0);
    check({tag, ".obj_found"}, 32'(obj_found), 0);
    check({tag, ".x_min"},     32'(x_min),     0);
    check({tag, ".x_max"},     32'(x_max),     0);
    check({tag, ".y_min"},     32'(y_min),     0);
    check({tag, ".y_max"},     32'(y_max),     0);
    check({tag, ".x_cen"},     32'(x_cen),     0);
    check({tag, ".y_cen"},     32'(y_cen),     0);
    check({tag, ".pix_cnt"},   32'(pix_cnt),   0);
  endtask

  function automatic bit [127:0] rand_img(input int dens);
    bit [127:0] im;
    for (int i = 0; i < 128; i++) im[i] = (int'($urandom_range(99)) < dens);
    return im;
  endfunction

  function automatic bit [127:0] block_img(input int npix);
    bit [127:0] im;
    int k;
    im = '0; k = 0;
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 4; x++) begin
        if (k < npix) im[y * W + x] = 1'b1;
        k++;
      end
    return im;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    rst = 1'b1; din = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    img_a = block_img(6);
    model(img_a, W * H);
    send_frame(img_a, W * H, 0, 1'b1);
    check_result("block");

    img_a = block_img(3);
    model(img_a, W * H);
    send_frame(img_a, W * H, 0, 1'b1);
    check_result("three_px");

    img_a = block_img(6);
    model(img_a, W * H);
    send_frame(img_a, W * H, 50, 1'b1);
    check_result("block_gaps");

    for (int t = 0; t < 6; t++) begin
      img_a = rand_img(int'($urandom_range(2, 40)));
      model(img_a, W * H);
      send_frame(img_a, W * H, int'($urandom_range(0, 60)), 1'b1);
      check_result($sformatf("rand%0d", t));
    end

    img_a = '1;
    model(img_a, 70);
    send_frame(img_a, 70, 20, 1'b1);
    check_result("long_sat");

    img_a = '1;
    model(img_a, 1);
    send_frame(img_a, 1, 0, 1'b1);
    check_result("one_pixel");

    img_a = rand_img(50);
    img_b = rand_img(30);
    r0 = res_cnt;
    send_frame(img_a, 3 * W, 30, 1'b0);
    model(img_b, W * H);
    send_frame(img_b, W * H, 30, 1'b1);
    check_result("abort");
    check("abort.res_count", 32'(res_cnt - r0), 1);

    send_frame(rand_img(60), 20, 0, 1'b0);
    rst = 1'b1;
    #2;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = res_cnt;
    for (int i = 0; i < 10; i++) drive_pixel(1'b1, 1'b0, i == 9, 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_ignore.res_count", 32'(res_cnt - r0), 0);
    img_b = rand_img(35);
    model(img_b, W * H);
    send_frame(img_b, W * H, 10, 1'b1);
    check_result("post_rst");
    check("post_rst.res_count", 32'(res_cnt - r0), 1);

    img_a = rand_img(40);
    img_b = rand_img(15);
    r0 = res_cnt;
    model(img_a, W * H);
    send_frame(img_a, W * H, 0, 1'b1);
    fork
      send_frame(img_b, W * H, 0, 1'b1);
      begin
        @(posedge clk); #1;
        check_outputs("b2b_first");
      end
    join
    model(img_b, W * H);
    check_result("b2b_second");
    check("b2b.res_count", 32'(res_cnt - r0), 2);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
